// File: rtl/sparse_idx_sampler.sv
// Fills the sparse-polynomial RAM h with H_DAT_DEP distinct indices < r, drawn from a random-word stream.
// Optional macro SAMPLER_REJCNT_EN adds rej_cnt, a saturating count of rejected draws.
module sparse_idx_sampler #(
    parameter int r         = 11027,
    parameter int H_ADDR_W  = 7,
    parameter int H_DAT_W   = 14,
    parameter int H_DAT_DEP = 67,
    parameter int R_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                done,
    input  logic                rand_valid,
    output logic                rand_ready,
    input  logic [R_W-1:0]      rand_data,
`ifdef SAMPLER_REJCNT_EN
    output logic [15:0]         rej_cnt,
`endif
    output logic [H_ADDR_W-1:0] h_addra,
    output logic                h_wea,
    output logic [H_DAT_W-1:0]  h_douta,
    output logic [H_ADDR_W-1:0] h_addrb,
    input  logic [H_DAT_W-1:0]  h_dinb
);

    typedef enum logic [2:0] {IDLE, DRAW, SCAN, WRITE, FIN} state_t;

    localparam logic [H_DAT_W-1:0]  R_LIM  = H_DAT_W'(r);
    localparam logic [H_ADDR_W-1:0] LAST_K = H_ADDR_W'(H_DAT_DEP - 1);

    state_t               state;
    logic [H_ADDR_W-1:0]  k;
    logic [H_ADDR_W-1:0]  j;
    logic [H_DAT_W-1:0]   cand;
    logic [H_DAT_W-1:0]   draw;
    logic                 hs;
    logic                 scan_hit;

    // A word transfers only when rand_valid and rand_ready coincide on a rising clk edge.
    assign hs       = rand_valid & rand_ready;
    assign draw     = rand_data[H_DAT_W-1:0];
    // h_dinb holds the entry addressed one cycle earlier, so the first SCAN cycle compares nothing.
    assign scan_hit = (j != '0) && (h_dinb == cand);

    generate
        if (R_W > H_DAT_W) begin : g_unused_upper
            logic unused_upper;
            assign unused_upper = ^rand_data[R_W-1:H_DAT_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            j          <= '0;
            cand       <= '0;
            done       <= 1'b0;
            rand_ready <= 1'b0;
            h_addra    <= '0;
            h_wea      <= 1'b0;
            h_douta    <= '0;
            h_addrb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k          <= '0;
                        state      <= DRAW;
                        rand_ready <= 1'b1;
                    end
                end
                DRAW: begin
                    if (hs) begin
                        cand <= draw;
                        if (draw < R_LIM) begin
                            rand_ready <= 1'b0;
                            if (k == '0) begin
                                state   <= WRITE;
                                h_wea   <= 1'b1;
                                h_addra <= k;
                                h_douta <= draw;
                            end else begin
                                state   <= SCAN;
                                j       <= '0;
                                h_addrb <= '0;
                            end
                        end
                    end
                end
                SCAN: begin
                    if (scan_hit) begin
                        state      <= DRAW;
                        rand_ready <= 1'b1;
                        h_addrb    <= '0;
                    end else if (j == k) begin
                        state   <= WRITE;
                        h_wea   <= 1'b1;
                        h_addra <= k;
                        h_douta <= cand;
                        h_addrb <= '0;
                    end else begin
                        j       <= j + 1'b1;
                        h_addrb <= (j + 1'b1 < k) ? j + 1'b1 : '0;
                    end
                end
                WRITE: begin
                    h_wea   <= 1'b0;
                    h_douta <= '0;
                    k       <= k + 1'b1;
                    if (k == LAST_K) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state      <= DRAW;
                        rand_ready <= 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SAMPLER_REJCNT_EN
    logic reject;
    assign reject = (state == DRAW && hs && draw >= R_LIM) || (state == SCAN && scan_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt <= '0;
        end else if (state == IDLE && start) begin
            rej_cnt <= '0;
        end else if (reject && rej_cnt != 16'hFFFF) begin
            rej_cnt <= rej_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sparse_idx_sampler.sv
// Directed bench for sparse_idx_sampler: behavioural dual-port h RAM, queued random-word source, write log.
// Build with SAMPLER_REJCNT_EN defined to also check rej_cnt.
module tb_sparse_idx_sampler;

    localparam int R        = 11027;
    localparam int AW       = 7;
    localparam int DW       = 14;
    localparam int DEP      = 67;
    localparam int RW       = 16;
    localparam int BASE_LAT = 2411;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          start      = 1'b0;
    logic          rand_valid = 1'b0;
    logic [RW-1:0] rand_data  = '0;
    logic          done;
    logic          rand_ready;
    logic [AW-1:0] h_addra;
    logic          h_wea;
    logic [DW-1:0] h_douta;
    logic [AW-1:0] h_addrb;
    logic [DW-1:0] h_dinb;
`ifdef SAMPLER_REJCNT_EN
    logic [15:0]   rej_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    sparse_idx_sampler #(.r(R), .H_ADDR_W(AW), .H_DAT_W(DW), .H_DAT_DEP(DEP), .R_W(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .rand_valid(rand_valid), .rand_ready(rand_ready), .rand_data(rand_data),
`ifdef SAMPLER_REJCNT_EN
        .rej_cnt(rej_cnt),
`endif
        .h_addra(h_addra), .h_wea(h_wea), .h_douta(h_douta),
        .h_addrb(h_addrb), .h_dinb(h_dinb)
    );

    always #5 clk = ~clk;

    // Random-word source: drives on negedge, front of rand_q is the offered word.
    logic [RW-1:0] rand_q[$];
    logic [DW-1:0] exp_q[$];
    bit            gap_en = 1'b0;
    bit            phase  = 1'b0;

    always @(negedge clk) begin
        phase      = gap_en ? ~phase : 1'b1;
        rand_valid = (rand_q.size() > 0) && phase;
        rand_data  = (rand_q.size() > 0) ? rand_q[0] : '0;
    end

    // RAM model with one-cycle read latency, plus handshake/write/done monitors.
    logic [DW-1:0] h_mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    int            cyc      = 0;
    int            hs_cnt   = 0;
    int            done_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (rand_valid && rand_ready) begin
            hs_cnt++;
            if (rand_q.size() > 0) void'(rand_q.pop_front());
        end
        if (h_wea) begin
            wr_addr_q.push_back(h_addra);
            wr_data_q.push_back(h_douta);
            wr_cyc_q.push_back(cyc);
            h_mem[h_addra] = h_douta;
        end
        if (done) done_cnt++;
        h_dinb <= h_mem[h_addrb];
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        exp_q.delete();
        rand_q.delete();
        hs_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic push_word(input logic [RW-1:0] w, input bit accepted);
        rand_q.push_back(w);
        if (accepted) exp_q.push_back(w[DW-1:0]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({done, rand_ready, h_wea} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: got done/ready/wea=%b want 000", {done, rand_ready, h_wea});
        end
        checks++;
        if (h_addra !== '0 || h_douta !== '0 || h_addrb !== '0) begin
            failures++;
            $display("FAIL reset_bus: got addra=%0d douta=%0d addrb=%0d want 0", h_addra, h_douta, h_addrb);
        end
`ifdef SAMPLER_REJCNT_EN
        checks++;
        if (rej_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_rejcnt: got %0d want 0", rej_cnt);
        end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sequential();
        int n;
        int rdy_seen;
        clear_logs();
        for (int v = 0; v < DEP; v++) push_word(RW'(v), 1'b1);
        repeat (2) @(negedge clk);
        pulse_start();
        wait_done(5000, n);
        checks++;
        if (n !== BASE_LAT) begin
            failures++;
            $display("FAIL seq_latency: got %0d cycles want %0d", n, BASE_LAT);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL seq_done_width: done still %b one cycle later want 0", done);
        end
        rdy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (rand_ready) rdy_seen++;
            @(negedge clk);
        end
        checks++;
        if (rdy_seen !== 0) begin
            failures++;
            $display("FAIL seq_ready_after_fin: got %0d ready cycles want 0", rdy_seen);
        end
        checks++;
        if (done_cnt !== 1 || hs_cnt !== DEP) begin
            failures++;
            $display("FAIL seq_counts: got done=%0d hs=%0d want 1 %0d", done_cnt, hs_cnt, DEP);
        end
        checks++;
        if (wr_data_q.size() !== DEP) begin
            failures++;
            $display("FAIL seq_nwrites: got %0d want %0d", wr_data_q.size(), DEP);
        end
        for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL seq_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                         i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
            end
        end
        checks++;
        if (wr_cyc_q[1] - wr_cyc_q[0] !== 4) begin
            failures++;
            $display("FAIL seq_gap01: got %0d want 4", wr_cyc_q[1] - wr_cyc_q[0]);
        end
    endtask

    task automatic test_range_reject();
        int n;
        clear_logs();
        push_word(16'd11027, 1'b0);
        push_word(16'd11026, 1'b1);
        for (int v = 0; v < DEP - 1; v++) push_word(RW'(v), 1'b1);
        repeat (2) @(negedge clk);
        pulse_start();
        wait_done(5000, n);
        checks++;
        if (n !== BASE_LAT + 1) begin
            failures++;
            $display("FAIL range_latency: got %0d want %0d", n, BASE_LAT + 1);
        end
        checks++;
        if (wr_data_q.size() !== DEP || hs_cnt !== DEP + 1) begin
            failures++;
            $display("FAIL range_counts: got writes=%0d hs=%0d want %0d %0d", wr_data_q.size(), hs_cnt, DEP, DEP + 1);
        end
        for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL range_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                         i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
            end
        end
`ifdef SAMPLER_REJCNT_EN
        checks++;
        if (rej_cnt !== 16'd1) begin
            failures++;
            $display("FAIL range_rejcnt: got %0d want 1", rej_cnt);
        end
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_dup_scan();
        int n;
        clear_logs();
        for (int v = 1; v <= 5; v++) push_word(RW'(v * 10), 1'b1);
        push_word(16'd30, 1'b0);
        push_word(16'd31, 1'b1);
        push_word(16'hC005, 1'b1);
        for (int v = 100; v < 160; v++) push_word(RW'(v), 1'b1);
        repeat (2) @(negedge clk);
        pulse_start();
        wait_done(5000, n);
        checks++;
        if (n !== BASE_LAT + 5) begin
            failures++;
            $display("FAIL dup_latency: got %0d want %0d", n, BASE_LAT + 5);
        end
        checks++;
        if (wr_cyc_q[5] - wr_cyc_q[4] !== 13) begin
            failures++;
            $display("FAIL dup_gap45: got %0d want 13", wr_cyc_q[5] - wr_cyc_q[4]);
        end
        checks++;
        if (wr_data_q.size() !== DEP || hs_cnt !== DEP + 1) begin
            failures++;
            $display("FAIL dup_counts: got writes=%0d hs=%0d want %0d %0d", wr_data_q.size(), hs_cnt, DEP, DEP + 1);
        end
        for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL dup_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                         i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
            end
        end
`ifdef SAMPLER_REJCNT_EN
        checks++;
        if (rej_cnt !== 16'd1) begin
            failures++;
            $display("FAIL dup_rejcnt: got %0d want 1", rej_cnt);
        end
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_valid_gaps();
        int n;
        clear_logs();
        gap_en = 1'b1;
        for (int v = 0; v < DEP; v++) push_word(RW'(v), 1'b1);
        repeat (2) @(negedge clk);
        pulse_start();
        wait_done(10000, n);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL gap_done: got done=%b after %0d cycles want 1", done, n);
        end
        repeat (2) @(negedge clk);
        gap_en = 1'b0;
        checks++;
        if (wr_data_q.size() !== DEP || hs_cnt !== DEP || done_cnt !== 1) begin
            failures++;
            $display("FAIL gap_counts: got writes=%0d hs=%0d done=%0d want %0d %0d 1",
                     wr_data_q.size(), hs_cnt, done_cnt, DEP, DEP);
        end
        for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL gap_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                         i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        for (int v = 0; v < DEP; v++) push_word(RW'(v), 1'b1);
        repeat (2) @(negedge clk);
        pulse_start();
        n = 0;
        while (wr_addr_q.size() < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        pulse_start();
        while (wr_addr_q.size() < 20 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wr_addr_q.size() !== 20 || wr_addr_q[19] !== AW'(19)) begin
            failures++;
            $display("FAIL mid_progress: got writes=%0d last_addr=%0d want 20 19", wr_addr_q.size(), wr_addr_q[19]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({done, rand_ready, h_wea} !== 3'b000 || h_addra !== '0 || h_douta !== '0 || h_addrb !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got done/ready/wea=%b addra=%0d douta=%0d addrb=%0d want all 0",
                     {done, rand_ready, h_wea}, h_addra, h_douta, h_addrb);
        end
        rand_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        for (int v = 0; v < DEP; v++) push_word(RW'(v), 1'b1);
        repeat (2) @(negedge clk);
        pulse_start();
        wait_done(5000, n);
        checks++;
        if (n !== BASE_LAT) begin
            failures++;
            $display("FAIL mid_restart_latency: got %0d want %0d", n, BASE_LAT);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_data_q.size() !== DEP || hs_cnt !== DEP) begin
            failures++;
            $display("FAIL mid_restart_counts: got writes=%0d hs=%0d want %0d %0d", wr_data_q.size(), hs_cnt, DEP, DEP);
        end
        for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL mid_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                         i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_range_reject();
        test_dup_scan();
        test_valid_gaps();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
